// File: rtl/vga_bin2bcd.sv
// Sequential 14-bit binary to 4-digit BCD converter (double dabble, one bit per cycle)
// with leading-zero blanking and an overflow dash code for the downstream digit renderer.
module vga_bin2bcd #(
  parameter logic [3:0] BLANK_CODE = 4'd15,
  parameter logic [3:0] OVF_CODE   = 4'd10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [13:0] bin,
  input  logic        blank_lz,
  output logic        busy,
  output logic        done,
  output logic [3:0]  digit0,
  output logic [3:0]  digit1,
  output logic [3:0]  digit2,
  output logic [3:0]  digit3
);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t          state;
  logic [13:0]     shreg;
  logic [15:0]     bcd;
  logic [3:0]      iter;
  logic            blank_q;
  logic            ovf_q;
  logic [3:0][3:0] dig_next;

  // One double-dabble iteration: +3 on every nibble >= 5, then shift in the next bin bit.
  function automatic logic [15:0] dabble_step(input logic [15:0] v, input logic lsb);
    logic [15:0] a;
    a = v;
    for (int i = 0; i < 4; i++) begin
      if (a[4*i +: 4] >= 4'd5) a[4*i +: 4] = a[4*i +: 4] + 4'd3;
    end
    return {a[14:0], lsb};
  endfunction

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    dig_next = bcd;
    if (ovf_q) begin
      dig_next = {4{OVF_CODE}};
    end else if (blank_q) begin
      if (bcd[15:12] == 4'd0) dig_next[3] = BLANK_CODE;
      if (bcd[15:8]  == 8'd0) dig_next[2] = BLANK_CODE;
      if (bcd[15:4]  == 12'd0) dig_next[1] = BLANK_CODE;
    end
  end

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      digit0  <= 4'd0;
      digit1  <= 4'd0;
      digit2  <= 4'd0;
      digit3  <= 4'd0;
      shreg   <= '0;
      bcd     <= '0;
      iter    <= '0;
      blank_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shreg   <= bin;
            blank_q <= blank_lz;
            ovf_q   <= (bin > 14'd9999);
            bcd     <= '0;
            iter    <= '0;
            busy    <= 1'b1;
            state   <= CONV;
          end
        end
        CONV: begin
          bcd   <= dabble_step(bcd, shreg[13]);
          shreg <= {shreg[12:0], 1'b0};
          iter  <= iter + 4'd1;
          if (iter == 4'd13) state <= DONE;
        end
        DONE: begin
          digit0 <= dig_next[0];
          digit1 <= dig_next[1];
          digit2 <= dig_next[2];
          digit3 <= dig_next[3];
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_bin2bcd.sv
// Self-checking bench for vga_bin2bcd: vector table, corner-case sequences and
// randomized traffic, all compared every cycle against an arithmetic timing/value model.
module tb_vga_bin2bcd;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [13:0] bin = '0;
  logic        blank_lz = 1'b0;
  logic        busy, done;
  logic [3:0]  digit0, digit1, digit2, digit3;

  vga_bin2bcd dut (
    .clk(clk), .rst(rst), .start(start), .bin(bin), .blank_lz(blank_lz),
    .busy(busy), .done(done),
    .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_done = 0;
  int done_cyc[$];

  // Reference model state
  bit          m_busy = 1'b0;
  bit          m_done = 1'b0;
  logic [15:0] m_dig = '0;
  int          rem = 0;
  int          cap_bin = 0;
  bit          cap_bl = 1'b0;

  typedef struct {
    int          value;
    bit          bl;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [15:0] expect_digits(input int v, input bit bl);
    int d[4];
    bit lead;
    if (v > 9999) return 16'hAAAA;
    for (int i = 0; i < 4; i++) d[i] = (v / (10 ** i)) % 10;
    if (bl) begin
      lead = 1'b1;
      for (int i = 3; i >= 1; i--) begin
        if (lead && d[i] == 0) d[i] = 15;
        else lead = 1'b0;
      end
    end
    return {d[3][3:0], d[2][3:0], d[1][3:0], d[0][3:0]};
  endfunction

  function automatic logic [15:0] dut_digits();
    return {digit3, digit2, digit1, digit0};
  endfunction

  // One clock: advance the model with the inputs seen at the edge, then compare at negedge.
  task automatic tick();
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_busy = 1'b0; m_done = 1'b0; m_dig = '0; rem = 0;
    end else begin
      m_done = 1'b0;
      if (rem > 0) begin
        rem--;
        if (rem == 0) begin
          m_dig  = expect_digits(cap_bin, cap_bl);
          m_done = 1'b1;
          m_busy = 1'b0;
        end
      end else if (start) begin
        cap_bin = int'(bin);
        cap_bl  = blank_lz;
        rem     = 15;
        m_busy  = 1'b1;
      end
    end
    @(negedge clk);
    check("busy", 16'(busy), 16'(m_busy));
    check("done", 16'(done), 16'(m_done));
    check("digits", dut_digits(), m_dig);
    if (done) begin
      n_done++;
      done_cyc.push_back(cyc);
    end
  endtask

  task automatic drive(input bit s, input int b, input bit bl);
    start = s;
    bin = 14'(b);
    blank_lz = bl;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20 && !done; i++) tick();
    check("done_timeout", 16'(done), 16'd1);
  endtask

  task automatic run_vec(input int b, input bit bl);
    drive(1'b1, b, bl);
    tick();
    drive(1'b0, 0, 1'b0);
    wait_done();
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    tick();
    tick();
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_done", 16'(done), 16'd0);
    check("rst_digits", dut_digits(), 16'h0000);
    rst = 1'b0;

    // Vector table
    vecs.push_back('{1234,  1'b0, 16'h1234});
    vecs.push_back('{0,     1'b1, 16'hFFF0});
    vecs.push_back('{40,    1'b1, 16'hFF40});
    vecs.push_back('{9999,  1'b0, 16'h9999});
    vecs.push_back('{10000, 1'b0, 16'hAAAA});
    vecs.push_back('{16383, 1'b1, 16'hAAAA});
    vecs.push_back('{0,     1'b0, 16'h0000});
    vecs.push_back('{7,     1'b1, 16'hFFF7});
    vecs.push_back('{100,   1'b1, 16'hF100});
    vecs.push_back('{1000,  1'b1, 16'h1000});
    vecs.push_back('{1009,  1'b1, 16'h1009});
    vecs.push_back('{5678,  1'b0, 16'h5678});
    foreach (vecs[i]) begin
      run_vec(vecs[i].value, vecs[i].bl);
      check($sformatf("vec%0d", i), dut_digits(), vecs[i].exp);
    end
    tick();
    check("hold_digits", dut_digits(), vecs[vecs.size()-1].exp);

    // Starts during CONV and on the DONE edge are ignored; k+16 is accepted
    begin
      int nd0;
      nd0 = n_done;
      drive(1'b1, 5, 1'b0); tick();                       // edge k
      drive(1'b0, 0, 1'b0); tick(); tick();               // k+1, k+2
      drive(1'b1, 77, 1'b0); tick();                      // k+3
      drive(1'b0, 0, 1'b0);
      for (int i = 0; i < 11; i++) tick();                // k+4..k+14
      drive(1'b1, 77, 1'b0); tick();                      // k+15
      check("ign_done", 16'(done), 16'd1);
      check("ign_digits", dut_digits(), 16'h0005);
      check("ign_busy", 16'(busy), 16'd0);
      tick();                                             // k+16 accepted
      check("k16_busy", 16'(busy), 16'd1);
      check("ign_ndone", 16'(n_done - nd0), 16'd1);
      drive(1'b0, 0, 1'b0);
      wait_done();
      check("k16_digits", dut_digits(), 16'h0077);
    end

    // Reset aborts a conversion; first edge after reset accepts start
    begin
      int nd0;
      tick();
      nd0 = n_done;
      drive(1'b1, 4321, 1'b0); tick();
      drive(1'b0, 0, 1'b0);
      for (int i = 0; i < 6; i++) tick();
      rst = 1'b1; tick();
      check("abort_busy", 16'(busy), 16'd0);
      check("abort_digits", dut_digits(), 16'h0000);
      rst = 1'b0;
      drive(1'b1, 4321, 1'b0); tick();
      check("post_rst_busy", 16'(busy), 16'd1);
      drive(1'b0, 0, 1'b0);
      wait_done();
      check("abort_ndone", 16'(n_done - nd0), 16'd1);
      check("post_rst_digits", dut_digits(), 16'h4321);
    end

    // Continuous start: one conversion every 16 cycles
    tick();
    done_cyc.delete();
    drive(1'b1, 8, 1'b0);
    for (int i = 0; i < 70; i++) tick();
    drive(1'b0, 0, 1'b0);
    check("cont_count", 16'(done_cyc.size()), 16'd4);
    for (int i = 1; i < done_cyc.size(); i++)
      check("cont_period", 16'(done_cyc[i] - done_cyc[i-1]), 16'd16);
    check("cont_digits", dut_digits(), 16'h0008);
    for (int i = 0; i < 20; i++) tick();

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      int b;
      case ($urandom_range(0, 3))
        0: b = $urandom_range(0, 99);
        1: b = $urandom_range(9990, 10010);
        default: b = $urandom_range(0, 16383);
      endcase
      drive(($urandom_range(0, 3) == 0), b, 1'($urandom_range(0, 1)));
      rst = ($urandom_range(0, 63) == 0);
      tick();
    end
    rst = 1'b0;
    drive(1'b0, 0, 1'b0);
    for (int i = 0; i < 20; i++) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
